mux16_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the 16-input single-bit select path (SixteenToOneMux) among 16 requesters. It holds a registered one-hot grant and 4-bit select, drives the select lines of an internally instanced 16:1 mux, and rotates priority so no requester starves. It sits between the requesting pipeline agents and the shared one-bit result line.

---
 rtl/mux16_rr_arbiter_if.sv | 21 ++
 rtl/mux16_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_mux16_rr_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mux16_rr_arbiter_if.sv
// Request/data/grant bundle between the requesting agents and the shared one-bit result arbiter.
// The agent side is master; the arbiter side is slave.
interface mux16_rr_arbiter_if;
  logic [15:0] req;
  logic [15:0] d;
  logic [15:0] gnt;
  logic [3:0]  sel;
  logic        busy;
  logic        out;
  logic        preempt;

  modport master (
    output req, d,
    input  gnt, sel, busy, out, preempt
  );

  modport slave (
    input  req, d,
    output gnt, sel, busy, out, preempt
  );
endinterface

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter over 16 requesters driving a 16:1 one-bit mux; grant 1 cycle after request, no backpressure.
// Optional hold-timeout preemption is enabled by defining ARB_TIMEOUT_EN.
module sixteen_to_one_mux (
  input  logic [15:0] d_i,
  input  logic [3:0]  sel_i,
  output logic        y_o
);
  assign y_o = d_i[sel_i];
endmodule

module mux16_rr_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic               clk,
  input  logic               reset,
  mux16_rr_arbiter_if.slave  bus
);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [3:0]  sel_q, sel_d;
  logic [15:0] gnt_q, gnt_d;
  logic [4:0]  pick_res;
  logic        mux_y;
`ifdef ARB_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
  logic        preempt_q, preempt_d;
`endif

  // Returns {found, index} of the first set bit of v searching p, p+1, ... mod 16.
  function automatic logic [4:0] rr_pick(input logic [15:0] v, input logic [3:0] p);
    logic [4:0] res;
    logic [3:0] k;
    res = 5'd0;
    for (int i = 15; i >= 0; i--) begin
      k = p + i[3:0];
      if (v[k]) res = {1'b1, k};
    end
    return res;
  endfunction

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    gnt_d    = gnt_q;
    pick_res = 5'd0;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    preempt_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          pick_res = rr_pick(bus.req, ptr_q);
        end
      end
      default: begin
        if (!bus.req[sel_q]) begin
          ptr_d    = sel_q + 4'd1;
          pick_res = rr_pick(bus.req & ~gnt_q, sel_q + 4'd1);
          if (!pick_res[4]) begin
            state_d = ST_IDLE;
            sel_d   = 4'd0;
            gnt_d   = 16'd0;
          end
        end
`ifdef ARB_TIMEOUT_EN
        // Holder still requesting but out of tenure: it competes last.
        else if (cnt_q == 8'(HOLD_MAX - 1)) begin
          ptr_d     = sel_q + 4'd1;
          pick_res  = rr_pick(bus.req, sel_q + 4'd1);
          preempt_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
    endcase
    if (pick_res[4]) begin
      state_d = ST_GRANT;
      sel_d   = pick_res[3:0];
      gnt_d   = 16'd1 << pick_res[3:0];
`ifdef ARB_TIMEOUT_EN
      cnt_d   = 8'd0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= 4'd0;
      sel_q   <= 4'd0;
      gnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= 8'd0;
      preempt_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
    end
  end
  assign bus.preempt = preempt_q;
`else
  assign bus.preempt = 1'b0;
`endif

  sixteen_to_one_mux u_mux (
    .d_i   (bus.d),
    .sel_i (sel_q),
    .y_o   (mux_y)
  );

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.busy = (state_q == ST_GRANT);
  assign bus.out  = (state_q == ST_GRANT) & mux_y;
endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Scoreboarded random + directed bench for mux16_rr_arbiter against a queue-free behavioural model.
module tb_mux16_rr_arbiter;
  localparam int HM = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mux16_rr_arbiter_if bif ();

  mux16_rr_arbiter #(.HOLD_MAX(HM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  typedef struct {
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        busy;
    logic        out;
    logic        pre;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;

  // Reference model: holder index (-1 = nobody), priority pointer, tenure length.
  int m_hold = -1;
  int m_ptr  = 0;
  int m_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [15:0] v, input int p);
    for (int k = 0; k < 16; k++) begin
      int idx;
      idx = (p + k) % 16;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic [15:0] r, input logic [15:0] dd);
    exp_t e;
    logic pre;
    logic [15:0] m;
    pre = 1'b0;
    if (m_hold < 0) begin
      if (r != 16'd0) begin
        m_hold = pick(r, m_ptr);
        m_cnt  = 0;
      end
    end else if (!r[m_hold]) begin
      m_ptr  = (m_hold + 1) % 16;
      m      = r;
      m[m_hold] = 1'b0;
      m_hold = pick(m, m_ptr);
      m_cnt  = 0;
    end else if (TMO && m_cnt == HM - 1) begin
      m_ptr  = (m_hold + 1) % 16;
      m_hold = pick(r, m_ptr);
      m_cnt  = 0;
      pre    = 1'b1;
    end else begin
      m_cnt++;
    end
    e.gnt  = (m_hold < 0) ? 16'd0 : (16'd1 << m_hold);
    e.sel  = (m_hold < 0) ? 4'd0 : 4'(m_hold);
    e.busy = (m_hold >= 0);
    e.out  = (m_hold >= 0) ? dd[m_hold] : 1'b0;
    e.pre  = pre;
    sbq.push_back(e);
  endtask

  task automatic step(input logic [15:0] r, input logic [15:0] dd);
    @(negedge clk);
    bif.req = r;
    bif.d   = dd;
    model_edge(r, dd);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    #3;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},  32'(bif.gnt),     32'h0);
    check({tag, "_sel"},  32'(bif.sel),     32'h0);
    check({tag, "_busy"}, 32'(bif.busy),    32'h0);
    check({tag, "_out"},  32'(bif.out),     32'h0);
    check({tag, "_pre"},  32'(bif.preempt), 32'h0);
  endtask

  // Monitor: every cycle's registered outputs, sampled 2 time units after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("gnt",  32'(bif.gnt),     32'(e.gnt));
        check("sel",  32'(bif.sel),     32'(e.sel));
        check("busy", 32'(bif.busy),    32'(e.busy));
        check("out",  32'(bif.out),     32'(e.out));
        check("pre",  32'(bif.preempt), 32'(e.pre));
      end
    end
  end

  initial begin
    logic [15:0] r;
    reset   = 1'b1;
    bif.req = 16'd0;
    bif.d   = 16'd0;
    #3;
    check_reset_outputs("por");
    #4;
    reset = 1'b0;

    // Single request, data high then low.
    step(16'h0010, 16'h0010);
    step(16'h0010, 16'h0000);
    step(16'h0000, 16'h0000);
    step(16'h0000, 16'h0000);

    // Rotation between 0 and 15.
    for (int i = 0; i < 3; i++) begin
      step(16'h8001, 16'h8001);
      step(16'h8001, 16'h0001);
      step(16'h8000, 16'h8000);
      step(16'h8001, 16'h8000);
      step(16'h8001, 16'h0001);
      step(16'h0001, 16'h8001);
    end
    step(16'h0000, 16'h0000);

    // Wrap-around from pointer 14.
    step(16'h2000, 16'hffff);
    step(16'h0003, 16'h0001);
    step(16'h0002, 16'h0002);
    step(16'h4002, 16'h4000);
    step(16'h4000, 16'h4000);
    step(16'h0000, 16'h0000);

    // Release to empty, then the same requester comes back.
    step(16'h0020, 16'h0020);
    step(16'h0000, 16'h0020);
    step(16'h0000, 16'h0020);
    step(16'h0020, 16'h0020);
    step(16'h0000, 16'h0000);

    // Asynchronous reset while 9 holds.
    step(16'h0200, 16'h0200);
    step(16'h0200, 16'h0200);
    drain();
    check("hold9_gnt", 32'(bif.gnt), 32'h0200);
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    reset  = 1'b0;
    m_hold = -1;
    m_ptr  = 0;
    m_cnt  = 0;
    step(16'h0200, 16'h0200);
    step(16'h0201, 16'h0001);
    step(16'h0000, 16'h0000);

    // Timeout scenarios (without preemption these are plain holds).
    for (int i = 0; i < 12; i++) step(16'h0006, 16'h0004);
    for (int i = 0; i < 10; i++) step(16'h0002, 16'h0002);
    step(16'h0000, 16'h0000);

    // Random traffic with sticky requests.
    r = 16'd0;
    for (int i = 0; i < 2000; i++) begin
      r = r ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      if ($urandom_range(0, 31) == 0) r = 16'd0;
      if ($urandom_range(0, 63) == 0) r = 16'd1 << $urandom_range(0, 15);
      step(r, 16'($urandom));
    end
    step(16'h0000, 16'h0000);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
